// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select: data has priority unless fetch has been passed over STARVE_MAX times.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int SW         = 3
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve_cnt,
    output owner_t        winner
);

    always_comb begin
        winner = OWN_IF;
        if (d_req && !(if_req && starve_cnt == SW'(STARVE_MAX)))
            winner = OWN_D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, with
// fetch anti-starvation and a watchdog that aborts transactions the memory never acks.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          busy,
    output logic          owner,
    output logic          err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        winner;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tout_q, tout_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .winner     (winner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        tout_d     = tout_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_d = winner;
                    tout_d  = '0;
                    state_d = ST_ACCESS;
                    if (winner == OWN_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        if (if_req && starve_q != SW'(STARVE_MAX))
                            starve_d = starve_q + SW'(1);
                    end else begin
                        addr_d   = if_addr;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        starve_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata_d  = mem_rdata;
                        else                  if_rdata_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end else if (tout_q == TW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th unacked ACCESS cycle: abort with zeroed read data.
                    err_d = 1'b1;
                    if (!we_q) begin
                        if (owner_q == OWN_D) d_rdata_d  = '0;
                        else                  if_rdata_d = '0;
                    end
                    state_d = ST_RESP;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            tout_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            tout_q     <= tout_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_we    = we_q && (state_q == ST_ACCESS);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_done   = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign d_done    = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;

endmodule
